conv3x3_stream: RTL and testbench

- Parametrised streaming successor to the fixed 8x8 / 3x3 / 2-bit convolution top.
- Accepts one raster-scan pixel per cycle over a valid/ready handshake and buffers two image rows in internal line buffers.
- Computes the 3x3 valid-region convolution, producing (IMG_W-2)x(IMG_H-2) results per frame with output backpressure.
- Coefficients load through a 9-word parallel port between frames.

---
 rtl/conv3x3_stream.sv | 239 +++++++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streaming 3x3 valid-region convolution over a raster-scan
// image delivered one pixel per cycle on a valid/ready handshake. Two line
// buffers hold the previous two rows; a window register holds the two most
// recent columns, and the incoming pixel column completes the 3x3 window.
// Results are registered (latency 1) and held under output backpressure.
// Coefficients are loaded through a 9-word parallel port while idle.
//
// Optional build macro: CONV3X3_SAT_EN
//   defined   -> out_data clamped to 2^PIX_W-1 (port width unchanged)
//   undefined -> full-precision sum on out_data
module conv3x3_stream #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int PIX_W  = 2,
    parameter int COEF_W = 2,
    localparam int OUT_W = PIX_W + COEF_W + 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  coef_load,
    input  logic [9*COEF_W-1:0]   coef_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PIX_W-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 2;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(2);
    localparam logic [RW-1:0] ROW_FIRST = RW'(2);
    localparam logic [CW-1:0] COL_INC   = CW'(1);
    localparam logic [RW-1:0] ROW_INC   = RW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                in_en_r;
    logic [CW-1:0]       col_r;
    logic [RW-1:0]       row_r;
    logic [COEF_W-1:0]   coef_r [0:8];

    // Line buffers: lb1_r holds the previous row, lb2_r the row before that.
    // The oldest entry of each (index IMG_W-1) lines up with the current column.
    logic [PIX_W-1:0]    lb1_r [0:IMG_W-1];
    logic [PIX_W-1:0]    lb2_r [0:IMG_W-1];

    // Stored window columns: [i][0] = column c-2, [i][1] = column c-1.
    // Column c comes straight from the line-buffer outputs and in_data.
    logic [PIX_W-1:0]    win_r [0:2][0:1];
    logic [PIX_W-1:0]    tap_s [0:2][0:2];

    logic                acc_s;
    logic                last_pix_s;
    logic                emit_s;
    logic                last_hs_s;
    logic [OUT_W-1:0]    sum_s;
    logic [OUT_W-1:0]    res_s;

`ifdef CONV3X3_SAT_EN
    // Clamp a full-precision sum to the pixel range.
    function automatic logic [OUT_W-1:0] clamp_pix(input logic [OUT_W-1:0] v);
        logic [OUT_W-1:0] lim;
        lim = {{(OUT_W-PIX_W){1'b0}}, {PIX_W{1'b1}}};
        if (v > lim) begin
            clamp_pix = lim;
        end else begin
            clamp_pix = v;
        end
    endfunction
`endif

    // A pixel is taken only while idle/running and the result slot can accept.
    assign in_ready   = in_en_r && (!out_valid || out_ready);
    assign acc_s      = in_valid && in_ready;
    assign last_pix_s = (row_r == ROW_LAST) && (col_r == COL_LAST);
    assign emit_s     = acc_s && (row_r >= ROW_FIRST) && (col_r >= COL_FIRST);
    assign last_hs_s  = out_valid && out_ready && out_last;

    // Frame sequencing: next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (acc_s && last_pix_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (last_hs_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered status flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            in_en_r    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_en_r    <= (state_s == ST_IDLE) || (state_s == ST_RUN);
            busy       <= (state_s == ST_RUN);
            frame_done <= (state_s == ST_DONE);
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= {CW{1'b0}};
            row_r <= {RW{1'b0}};
        end else if (state_r == ST_DONE) begin
            col_r <= {CW{1'b0}};
            row_r <= {RW{1'b0}};
        end else if (acc_s) begin
            if (col_r == COL_LAST) begin
                col_r <= {CW{1'b0}};
                if (row_r == ROW_LAST) begin
                    row_r <= {RW{1'b0}};
                end else begin
                    row_r <= row_r + ROW_INC;
                end
            end else begin
                col_r <= col_r + COL_INC;
            end
        end
    end

    // Coefficient bank: loadable only while idle (including with the first pixel).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) begin
                coef_r[k] <= {COEF_W{1'b0}};
            end
        end else if ((state_r == ST_IDLE) && coef_load) begin
            for (int k = 0; k < 9; k++) begin
                coef_r[k] <= coef_in[k*COEF_W +: COEF_W];
            end
        end
    end

    // Line buffers and window columns shift once per accepted pixel.
    always_ff @(posedge clk) begin
        if (acc_s) begin
            lb1_r[0] <= in_data;
            lb2_r[0] <= lb1_r[IMG_W-1];
            for (int k = 1; k < IMG_W; k++) begin
                lb1_r[k] <= lb1_r[k-1];
                lb2_r[k] <= lb2_r[k-1];
            end
            for (int i = 0; i < 3; i++) begin
                win_r[i][0] <= win_r[i][1];
                win_r[i][1] <= tap_s[i][2];
            end
        end
    end

    // Assemble the full 3x3 window seen by the pixel currently offered.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tap_s[i][0] = win_r[i][0];
            tap_s[i][1] = win_r[i][1];
        end
        tap_s[0][2] = lb2_r[IMG_W-1];
        tap_s[1][2] = lb1_r[IMG_W-1];
        tap_s[2][2] = in_data;
    end

    // Full-precision multiply-accumulate over the window.
    always_comb begin
        sum_s = {OUT_W{1'b0}};
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                sum_s = sum_s + (OUT_W'(coef_r[3*i+j]) * OUT_W'(tap_s[i][j]));
            end
        end
    end

    // Final result formatting (optional clamp).
    always_comb begin
`ifdef CONV3X3_SAT_EN
        res_s = clamp_pix(sum_s);
`else
        res_s = sum_s;
`endif
    end

    // Output slot: load on a completing pixel, hold under backpressure, clear after handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= {OUT_W{1'b0}};
            out_last  <= 1'b0;
        end else if (emit_s) begin
            out_valid <= 1'b1;
            out_data  <= res_s;
            out_last  <= last_pix_s;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed table-driven bench for conv3x3_stream (8x8 image, 2-bit pixels and
// coefficients). Each table row describes one frame; expected results come from
// hand-computed first/last constants plus a direct 2D convolution of the image.
module tb_conv3x3_stream;

    localparam logic [17:0] CENTRE = 18'h00100;
    localparam logic [17:0] ONES   = 18'h15555;
    localparam logic [17:0] THREES = 18'h3FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        coef_load = 1'b0;
    logic [17:0] coef_in = 18'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_data = 2'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        frame_done;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [17:0] model_coef = 18'h0;
    int          res_q[$];

    typedef struct {
        int          pat;
        int          ld_mode;   // 0 none, 1 load in idle before frame, 2 load with first pixel
        logic [17:0] coef;
        bit          mid_ld;    // attempt a centre-filter load while running
        int          stall_at;  // cycle index of a 5-cycle out_ready drop, -1 none
        int          exp_first;
        int          exp_last;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    conv3x3_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coef_load  (coef_load),
        .coef_in    (coef_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    function automatic int pix(input int pat, input int r, input int c);
        case (pat)
            0:       return (r + c) % 4;
            1:       return 1;
            2:       return 3;
            default: return (3 * r + c) % 4;
        endcase
    endfunction

    function automatic int sat(input int v);
`ifdef CONV3X3_SAT_EN
        return (v > 3) ? 3 : v;
`else
        return v;
`endif
    endfunction

    function automatic int model(input int pat, input int n, input logic [17:0] k);
        int r0;
        int c0;
        int s;
        r0 = n / 6;
        c0 = n % 6;
        s  = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s += int'(k[(3*i+j)*2 +: 2]) * pix(pat, r0 + i, c0 + j);
            end
        end
        return sat(s);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int abort_at, output bit aborted);
        int pix_i;
        int cyc;
        int hold;
        bit got_last;
        bit stalled_prev;
        bit busy_seen;
        bit in_stall;
        pix_i = 0; cyc = 0; hold = 0;
        got_last = 1'b0; stalled_prev = 1'b0; busy_seen = 1'b0;
        aborted = 1'b0;
        res_q.delete();
        if (v.ld_mode == 1) begin
            @(negedge clk);
            coef_in = v.coef; coef_load = 1'b1;
            @(negedge clk);
            coef_load = 1'b0;
            model_coef = v.coef;
        end else if (v.ld_mode == 2) begin
            model_coef = v.coef;
        end
        while (!got_last && cyc < 2000) begin
            @(negedge clk);
            in_stall = (v.stall_at >= 0) && (cyc >= v.stall_at) && (cyc < v.stall_at + 5);
            in_valid = (pix_i < 64);
            in_data  = 2'(pix(v.pat, pix_i / 8, pix_i % 8));
            if (v.ld_mode == 2 && pix_i == 0) begin
                coef_load = 1'b1; coef_in = v.coef;
            end else if (v.mid_ld && pix_i >= 10 && pix_i < 12) begin
                coef_load = 1'b1; coef_in = CENTRE;
            end else begin
                coef_load = 1'b0;
            end
            out_ready = !in_stall;
            #1;
            if (in_stall && out_valid) begin
                chk("stall_in_ready", int'(in_ready), 0);
                if (stalled_prev) chk("stall_hold", int'(out_data), hold);
            end
            stalled_prev = out_valid && !out_ready;
            hold = int'(out_data);
            if (!busy_seen && pix_i == 32) begin
                chk("busy_run", int'(busy), 1);
                busy_seen = 1'b1;
            end
            if (out_valid && out_ready) begin
                res_q.push_back(int'(out_data));
                chk("out_last", int'(out_last), int'(res_q.size() == 36));
                if (out_last) got_last = 1'b1;
            end
            if (in_valid && in_ready) pix_i++;
            cyc++;
            if (abort_at > 0 && pix_i == abort_at) begin
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) return;
        chk("frame_complete", int'(got_last), 1);
        chk("result_count", res_q.size(), 36);
        if (res_q.size() == 36) begin
            chk("first_result", res_q[0], sat(v.exp_first));
            chk("last_result", res_q[35], sat(v.exp_last));
            for (int n = 0; n < 36; n++) begin
                chk($sformatf("result_%0d", n), res_q[n], model(v.pat, n, model_coef));
            end
        end
        @(negedge clk);
        in_valid = 1'b0; coef_load = 1'b0; out_ready = 1'b1;
        #1;
        chk("frame_done_pulse", int'(frame_done), 1);
        chk("busy_done", int'(busy), 0);
        @(negedge clk);
        #1;
        chk("frame_done_clear", int'(frame_done), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   int'(in_ready), 0);
        chk({tag, "_out_valid"},  int'(out_valid), 0);
        chk({tag, "_out_data"},   int'(out_data), 0);
        chk({tag, "_out_last"},   int'(out_last), 0);
        chk({tag, "_busy"},       int'(busy), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   ab;
        vec_t v;
        vecs[0] = '{pat:0, ld_mode:2, coef:CENTRE, mid_ld:1'b0, stall_at:-1, exp_first:2,  exp_last:0};
        vecs[1] = '{pat:1, ld_mode:1, coef:ONES,   mid_ld:1'b0, stall_at:-1, exp_first:9,  exp_last:9};
        vecs[2] = '{pat:2, ld_mode:2, coef:THREES, mid_ld:1'b0, stall_at:-1, exp_first:81, exp_last:81};
        vecs[3] = '{pat:3, ld_mode:1, coef:ONES,   mid_ld:1'b0, stall_at:30, exp_first:12, exp_last:12};
        vecs[4] = '{pat:1, ld_mode:0, coef:ONES,   mid_ld:1'b1, stall_at:-1, exp_first:9,  exp_last:9};
        vecs[5] = '{pat:0, ld_mode:1, coef:CENTRE, mid_ld:1'b0, stall_at:-1, exp_first:2,  exp_last:0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_busy", int'(busy), 0);

        // Frames from the table, back to back
        for (int t = 0; t < 6; t++) begin
            run_frame(vecs[t], 0, ab);
        end

        // Abort mid-frame with reset, then a fresh frame
        v = '{pat:1, ld_mode:1, coef:ONES, mid_ld:1'b0, stall_at:-1, exp_first:9, exp_last:9};
        run_frame(v, 20, ab);
        chk("abort_reached", int'(ab), 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        model_coef = 18'h0;
        in_valid = 1'b0; coef_load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("restart_in_ready", int'(in_ready), 1);
        v = '{pat:1, ld_mode:2, coef:ONES, mid_ld:1'b0, stall_at:-1, exp_first:9, exp_last:9};
        run_frame(v, 0, ab);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
